// File: rtl/sva_seq_pkg.sv
// Shared types and stimulus tables for the three-phase implication sequencer.
package sva_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    P_VAC,
    P_HOLD,
    P_VIOL,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RES_VAC,
    RES_PASS,
    RES_FAIL
  } result_t;

  // {ant, data} levels driven while in a given state
  function automatic logic [1:0] stim_levels(input state_t s);
    case (s)
      P_HOLD:  return 2'b10;
      P_VIOL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic in_phase(input state_t s);
    return (s == P_VAC) || (s == P_HOLD) || (s == P_VIOL);
  endfunction

endpackage

// File: rtl/sva_impl_scorer.sv
// Scores one implication attempt per enabled cycle into saturating vacuous/pass/fail counters.
module sva_impl_scorer
  import sva_seq_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  input  logic          nonoverlap,
  input  logic          ant,
  input  logic          data,
  output logic          fail_pulse,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] vac_cnt,
  output logic [CW-1:0] fail_cnt
);

  logic    prev_ant;
  logic    a_eff;
  result_t kind;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + CW'(1);
  endfunction

  // Non-overlapped scoring looks at the antecedent one cycle back
  always_comb begin
    a_eff = nonoverlap ? prev_ant : ant;
    if (!a_eff)
      kind = RES_VAC;
    else if (data)
      kind = RES_FAIL;
    else
      kind = RES_PASS;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev_ant   <= 1'b0;
      fail_pulse <= 1'b0;
      pass_cnt   <= '0;
      vac_cnt    <= '0;
      fail_cnt   <= '0;
    end else begin
      fail_pulse <= en && (kind == RES_FAIL);
      if (en) begin
        prev_ant <= ant;
        case (kind)
          RES_VAC:  vac_cnt  <= sat_inc(vac_cnt);
          RES_PASS: pass_cnt <= sat_inc(pass_cnt);
          default:  fail_cnt <= sat_inc(fail_cnt);
        endcase
      end
    end
  end

endmodule

// File: rtl/sva_phase_sequencer.sv
// Three-phase (vacuous, hold, violation) stimulus FSM driving an implication scorer.
module sva_phase_sequencer
  import sva_seq_pkg::*;
#(
  parameter int CW = 8,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] cfg_len,
  input  logic          cfg_nonoverlap,
  output logic          ant_o,
  output logic          data_o,
  output logic          busy,
  output logic          done,
  output logic          fail_pulse,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] vac_cnt,
  output logic [CW-1:0] fail_cnt
);

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] len_q;
  logic [LW-1:0] phase_cnt;
  logic [LW-1:0] phase_cnt_nxt;
  logic          nonoverlap_q;
  logic          accept;

  function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] l);
    return (l == '0) ? LW'(1) : l;
  endfunction

  always_comb begin
    state_nxt     = state;
    phase_cnt_nxt = phase_cnt;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept        = 1'b1;
          state_nxt     = P_VAC;
          phase_cnt_nxt = eff_len(cfg_len) - LW'(1);
        end
      end
      P_VAC, P_HOLD, P_VIOL: begin
        if (phase_cnt == '0) begin
          phase_cnt_nxt = len_q - LW'(1);
          case (state)
            P_VAC:   state_nxt = P_HOLD;
            P_HOLD:  state_nxt = P_VIOL;
            default: state_nxt = DONE;
          endcase
        end else begin
          phase_cnt_nxt = phase_cnt - LW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so a state's levels show in its first cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase_cnt    <= '0;
      len_q        <= '0;
      nonoverlap_q <= 1'b0;
      ant_o        <= 1'b0;
      data_o       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state             <= state_nxt;
      phase_cnt         <= phase_cnt_nxt;
      {ant_o, data_o}   <= stim_levels(state_nxt);
      busy              <= in_phase(state_nxt);
      done              <= (state_nxt == DONE);
      if (accept) begin
        len_q        <= eff_len(cfg_len);
        nonoverlap_q <= cfg_nonoverlap;
      end
    end
  end

  sva_impl_scorer #(
    .CW(CW)
  ) u_scorer (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .en        (busy),
    .nonoverlap(nonoverlap_q),
    .ant       (ant_o),
    .data      (data_o),
    .fail_pulse(fail_pulse),
    .pass_cnt  (pass_cnt),
    .vac_cnt   (vac_cnt),
    .fail_cnt  (fail_cnt)
  );

endmodule

// File: tb/tb_sva_phase_sequencer.sv
// Scoreboard bench: expected run results are queued at start, popped and compared on done.
module tb_sva_phase_sequencer;

  typedef struct {
    int e_vac;
    int e_pass;
    int e_fail;
    int e_busy;
    int e_fp;
    int e_ant;
    int e_data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start2;
  logic [7:0] cfg_len;
  logic       cfg_nonoverlap;

  logic       ant_o, data_o, busy, done, fail_pulse;
  logic [7:0] pass_cnt, vac_cnt, fail_cnt;
  logic       ant2, data2, busy2, done2, fp2;
  logic [1:0] pass2, vac2, fail2;

  int total = 0;
  int bad   = 0;

  exp_t q[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  sva_phase_sequencer #(.CW(8), .LW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .cfg_nonoverlap(cfg_nonoverlap), .ant_o(ant_o), .data_o(data_o),
    .busy(busy), .done(done), .fail_pulse(fail_pulse),
    .pass_cnt(pass_cnt), .vac_cnt(vac_cnt), .fail_cnt(fail_cnt)
  );

  sva_phase_sequencer #(.CW(2), .LW(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .cfg_len(cfg_len),
    .cfg_nonoverlap(cfg_nonoverlap), .ant_o(ant2), .data_o(data2),
    .busy(busy2), .done(done2), .fail_pulse(fp2),
    .pass_cnt(pass2), .vac_cnt(vac2), .fail_cnt(fail2)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int v, input int p, input int f, input int b,
                              input int fp, input int a, input int d);
    exp_t e;
    e.e_vac = v; e.e_pass = p; e.e_fail = f; e.e_busy = b;
    e.e_fp = fp; e.e_ant = a; e.e_data = d;
    return e;
  endfunction

  // Monitor for the 8-bit instance: accumulates a run, scores it on done
  int         m_busy = 0;
  int         m_fp = 0;
  logic [63:0] m_ant = '0;
  logic [63:0] m_data = '0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      m_busy = 0; m_fp = 0; m_ant = '0; m_data = '0;
    end else begin
      if (busy) begin
        m_busy++;
        m_ant  = {m_ant[62:0], ant_o};
        m_data = {m_data[62:0], data_o};
      end
      if (fail_pulse) m_fp++;
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("vac_cnt", int'(vac_cnt), e.e_vac);
          check("pass_cnt", int'(pass_cnt), e.e_pass);
          check("fail_cnt", int'(fail_cnt), e.e_fail);
          check("busy_cycles", m_busy, e.e_busy);
          check("fail_pulse_cycles", m_fp, e.e_fp);
          check("ant_seq", int'(m_ant[31:0]), e.e_ant);
          check("data_seq", int'(m_data[31:0]), e.e_data);
        end
        m_busy = 0; m_fp = 0; m_ant = '0; m_data = '0;
      end
    end
  end

  // Monitor for the 2-bit saturating instance
  always @(posedge clk) begin
    #1;
    if (!rst && done2) begin
      if (q2.size() == 0) begin
        check("unexpected_done2", 1, 0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("sat_vac", int'(vac2), e.e_vac);
        check("sat_pass", int'(pass2), e.e_pass);
        check("sat_fail", int'(fail2), e.e_fail);
      end
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", int'(done), 1);
  endtask

  task automatic run(input int len, input bit nonov, input exp_t e);
    q.push_back(e);
    cfg_len = 8'(len);
    cfg_nonoverlap = nonov;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_ant"}, int'(ant_o), 0);
    check({tag, "_data"}, int'(data_o), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_fp"}, int'(fail_pulse), 0);
    check({tag, "_cnts"}, int'(vac_cnt) + int'(pass_cnt) + int'(fail_cnt), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    cfg_len = 8'd4; cfg_nonoverlap = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_cnt2", int'(vac2) + int'(pass2) + int'(fail2), 0);
    rst = 1'b0;
    @(negedge clk);

    // overlapped, length 4
    run(4, 1'b0, mk(4, 4, 4, 12, 4, 'h0FF, 'h00F));
    // counters hold into IDLE
    check("hold_vac", int'(vac_cnt), 4);
    // non-overlapped, length 4
    run(4, 1'b1, mk(5, 3, 4, 12, 4, 'h0FF, 'h00F));
    // length 0 behaves as 1
    run(0, 1'b0, mk(1, 1, 1, 3, 1, 'h3, 'h1));

    // mid-run reset during P_HOLD
    cfg_len = 8'd4; cfg_nonoverlap = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("hold_phase_ant", int'(ant_o), 1);
    check("hold_phase_data", int'(data_o), 0);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check_idle("midrst");
    repeat (20) @(negedge clk);
    check("midrst_no_done", int'(busy), 0);
    run(4, 1'b0, mk(4, 4, 4, 12, 4, 'h0FF, 'h00F));

    // start held through a whole run: one run, then a fresh one from IDLE
    q.push_back(mk(2, 2, 2, 6, 2, 'h0F, 'h03));
    q.push_back(mk(2, 2, 2, 6, 2, 'h0F, 'h03));
    cfg_len = 8'd2; cfg_nonoverlap = 1'b0;
    start = 1'b1;
    @(negedge clk);
    wait_done(200);
    @(negedge clk);
    @(negedge clk);
    check("restart_busy", int'(busy), 1);
    start = 1'b0;
    wait_done(200);
    @(negedge clk);

    // saturation on the 2-bit instance
    q2.push_back(mk(3, 3, 3, 0, 0, 0, 0));
    cfg_len = 8'd6; cfg_nonoverlap = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    begin
      int n = 0;
      while (!done2 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("done2_timeout", int'(done2), 1);
    end
    repeat (3) @(negedge clk);

    check("queue_drained", q.size() + q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
